// File: rtl/load_store_unit_if.sv
// load_store_unit_if: execute-stage request/response handshake plus the data-memory port
interface load_store_unit_if #(parameter int ADDR_W = 12);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic [1:0]        resp_err;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [2:0]        dmem_sel;
    logic              dmem_write;
    logic [31:0]       dmem_rdata;
    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, dmem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, dmem_addr, dmem_wdata, dmem_sel, dmem_write
    );
    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, dmem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, dmem_addr, dmem_wdata, dmem_sel, dmem_write
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time RISC-V load/store requester for the byte-addressed data memory
module load_store_unit #(
    parameter int ADDR_W      = 12,
    parameter bit CHECK_ALIGN = 1
) (
    input logic             clk,
    input logic             rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      state, state_n;
    logic        store_q;
    logic [2:0]  f3_q;
    logic [1:0]  sz;
    logic        illegal, misaligned, fault, accept;
    logic [1:0]  err;
    logic [32:0] last_byte;
    logic [31:0] ext;
    always_comb begin
        sz         = bus.req_funct3[1:0];
        illegal    = bus.req_store ? (bus.req_funct3[2] || sz == 2'b11)
                                   : (sz == 2'b11 || bus.req_funct3 == 3'b110);
        misaligned = CHECK_ALIGN && ((sz == 2'd1 && bus.req_addr[0]) || (sz == 2'd2 && bus.req_addr[1:0] != 2'b00));
        // Last byte touched, kept at 33 bits so a wrap past 2^32 still reads as out of range
        last_byte  = {1'b0, bus.req_addr} + ((33'd1 << sz) - 33'd1);
        fault      = last_byte[32:ADDR_W] != '0;
        err        = illegal ? 2'd3 : misaligned ? 2'd1 : fault ? 2'd2 : 2'd0;
        accept     = state == IDLE && bus.req_valid;
        ext        = f3_q[1] ? bus.dmem_rdata
                   : f3_q[0] ? {{16{~f3_q[2] & bus.dmem_rdata[15]}}, bus.dmem_rdata[15:0]}
                             : {{24{~f3_q[2] & bus.dmem_rdata[7]}}, bus.dmem_rdata[7:0]};
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.req_valid) state_n = err == 2'd0 ? ACCESS : RESP;
            ACCESS:  state_n = RESP;
            RESP:    if (bus.resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        bus.req_ready  = state == IDLE;
        bus.resp_valid = state == RESP;
        bus.dmem_write = state == ACCESS && store_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_q         <= 1'b0;
            f3_q            <= '0;
            bus.dmem_addr   <= '0;
            bus.dmem_wdata  <= '0;
            bus.dmem_sel    <= '0;
            bus.resp_rdata  <= '0;
            bus.resp_err    <= '0;
        end else begin
            if (accept) begin
                bus.resp_err   <= err;
                bus.resp_rdata <= '0;
                if (err == 2'd0) begin
                    store_q        <= bus.req_store;
                    f3_q           <= bus.req_funct3;
                    bus.dmem_addr  <= bus.req_addr[ADDR_W-1:0];
                    bus.dmem_wdata <= bus.req_wdata;
                    bus.dmem_sel   <= {1'b0, sz};
                end
            end
            if (state == ACCESS) bus.resp_rdata <= store_q ? 32'd0 : ext;
        end
    end
endmodule
